sum4b_arb2: RTL

Two-port round-robin arbiter that time-shares a single `sum4b` 4-bit adder between two independent requesters. Each requester presents operand pairs over a valid/ready handshake; the block grants at most one request per cycle, drives the shared adder, and holds each result in a per-requester response register with its own valid/ready handshake. It sits between requester logic and one `sum4b` instance, which it instantiates internally.

---
 rtl/sum4b_arb2.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sum4b_arb2.sv
// sum4b_arb2 -- two-port round-robin arbiter sharing one 4-bit adder.
//
// Purpose:
//   Two independent requesters present operand pairs over valid/ready.
//   At most one request is granted per cycle. The granted operands drive a
//   single sum4b adder. The result is held in that port's response register,
//   which has its own valid/ready handshake toward the consumer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/ready/a/b      requester 0 handshake and 4-bit operands
//   req1_valid/ready/a/b      requester 1 handshake and 4-bit operands
//   rsp0_valid/ready/sum/cout response 0 handshake, 4-bit sum and carry
//   rsp1_valid/ready/sum/cout response 1 handshake, 4-bit sum and carry
//   gnt_cnt0, gnt_cnt1        saturating 8-bit accepted-request counters
//
// Parameter:
//   PRIO_INIT                 port that wins the first contest after reset

// Plain 4-bit unsigned adder with carry-in fixed at 0.
module sum4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

module sum4b_arb2 #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,

  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [3:0] rsp0_sum,
  output logic       rsp0_cout,

  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp1_sum,
  output logic       rsp1_cout,

  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  // Pointer to the port granted most recently; the other port wins a tie.
  logic       last;

  logic       elig0;
  logic       elig1;
  logic       gnt0;
  logic       gnt1;

  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_cout;

  // A port may only be granted if its response slot is empty or is being
  // drained in this same cycle, so a new result never overwrites an unread one.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  // Grant decision. Reset suppresses every grant so nothing is captured or
  // counted while rst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        gnt0 = last;
        gnt1 = ~last;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operand mux for the shared adder. Idle cycles feed zeros so the adder
  // inputs do not toggle with whatever an ungranted requester presents.
  always_comb begin
    add_a = 4'd0;
    add_b = 4'd0;
    if (gnt0) begin
      add_a = req0_a;
      add_b = req0_b;
    end else if (gnt1) begin
      add_a = req1_a;
      add_b = req1_b;
    end
  end

  sum4b u_sum4b (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Round-robin pointer. Reset loads the complement of PRIO_INIT so that
  // PRIO_INIT is the winner of the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ~PRIO_INIT;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end

  // Response register 0. A grant takes precedence over a pop, which lets a
  // pop and a refill happen in the same cycle without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_sum   <= 4'd0;
      rsp0_cout  <= 1'b0;
    end else if (gnt0) begin
      rsp0_valid <= 1'b1;
      rsp0_sum   <= add_sum;
      rsp0_cout  <= add_cout;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Response register 1, same behaviour as port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_sum   <= 4'd0;
      rsp1_cout  <= 1'b0;
    end else if (gnt1) begin
      rsp1_valid <= 1'b1;
      rsp1_sum   <= add_sum;
      rsp1_cout  <= add_cout;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

  // Grant counters stick at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else begin
      if (gnt0 && (gnt_cnt0 != 8'hFF)) begin
        gnt_cnt0 <= gnt_cnt0 + 8'd1;
      end
      if (gnt1 && (gnt_cnt1 != 8'hFF)) begin
        gnt_cnt1 <= gnt_cnt1 + 8'd1;
      end
    end
  end

endmodule
